// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between instruction fetch (I) and load/store (D) with
// bounded fetch starvation and a sticky timeout. MEM_ARB_STATS_EN adds stall counters.
module mem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int STARVE_N = 4,
  parameter int TIMEOUT  = 255
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              ihit,
  output logic [DATA_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              dhit,
  output logic [DATA_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic              ram_ready,
  output logic              arb_err
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [31:0]       istall_cnt,
  output logic [31:0]       dstall_cnt
`endif
);

  // state | meaning
  // IDLE  | no grant; arbitrate every cycle, RAM strobes low
  // DSERV | D-port owns the RAM until ram_ready, drop or timeout
  // ISERV | I-port owns the RAM until ram_ready, drop or timeout
  typedef enum logic [1:0] {IDLE, DSERV, ISERV} state_t;

  localparam int              SW          = $clog2(STARVE_N + 1);
  localparam logic [SW-1:0]   STARVE_MAX  = SW'(STARVE_N);
  localparam logic [7:0]      TIMEOUT_CNT = 8'(TIMEOUT);

  state_t        state, state_nxt, arb_pick;
  logic [SW-1:0] starve_cnt, starve_nxt;
  logic [7:0]    timer, timer_nxt;
  logic          err_nxt;
  logic          arb_evt;
  logic          dreq;

  assign dreq = dREN | dWEN;

  always_comb begin
    if (dreq && (starve_cnt < STARVE_MAX)) arb_pick = DSERV;
    else if (iREN)                         arb_pick = ISERV;
    else if (dreq)                         arb_pick = DSERV;
    else                                   arb_pick = IDLE;
  end

  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    err_nxt   = arb_err;
    arb_evt   = 1'b0;
    ihit      = 1'b0;
    dhit      = 1'b0;
    iload     = '0;
    dload     = '0;
    ramREN    = 1'b0;
    ramWEN    = 1'b0;
    ramaddr   = '0;
    ramstore  = '0;
    case (state)
      IDLE: arb_evt = 1'b1;
      DSERV: begin
        // a simultaneous read and write request is serviced as a write
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        ramaddr  = daddr;
        ramstore = dstore;
        if (!dreq) begin
          state_nxt = IDLE;
        end else if (ram_ready) begin
          dhit    = 1'b1;
          dload   = ramload;
          arb_evt = 1'b1;
        end else if (timer == TIMEOUT_CNT) begin
          err_nxt   = 1'b1;
          state_nxt = IDLE;
        end else begin
          timer_nxt = timer + 8'd1;
        end
      end
      ISERV: begin
        ramREN  = iREN;
        ramaddr = iaddr;
        if (!iREN) begin
          state_nxt = IDLE;
        end else if (ram_ready) begin
          ihit    = 1'b1;
          iload   = ramload;
          arb_evt = 1'b1;
        end else if (timer == TIMEOUT_CNT) begin
          err_nxt   = 1'b1;
          state_nxt = IDLE;
        end else begin
          timer_nxt = timer + 8'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (arb_evt) state_nxt = arb_pick;
    // every new grant, including a back-to-back re-grant of the same port, starts a fresh timer
    if (arb_evt || (state_nxt != state)) timer_nxt = '0;
  end

  always_comb begin
    starve_nxt = starve_cnt;
    if (!iREN) begin
      starve_nxt = '0;
    end else if (arb_evt) begin
      if (arb_pick == ISERV)
        starve_nxt = '0;
      else if ((arb_pick == DSERV) && (starve_cnt < STARVE_MAX))
        starve_nxt = starve_cnt + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= IDLE;
      starve_cnt <= '0;
      timer      <= '0;
      arb_err    <= 1'b0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
      timer      <= timer_nxt;
      arb_err    <= err_nxt;
    end
  end

`ifdef MEM_ARB_STATS_EN
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      istall_cnt <= '0;
      dstall_cnt <= '0;
    end else begin
      if (iREN && !ihit) istall_cnt <= istall_cnt + 32'd1;
      if (dreq && !dhit) dstall_cnt <= dstall_cnt + 32'd1;
    end
  end
`endif

endmodule
